register_file: RTL and testbench

Sixteen-entry, 16-bit general register file for the tiny16 CPU, sitting directly downstream of the instruction controller. It consumes the controller's register select and enable strobes, drives the selected register onto the shared data bus, and captures bus data into the destination register. It also owns the PC and SP increment/decrement hardware, so the fetch, PUSH and POP sequences need no ALU cycle.

---
 rtl/tiny16_pkg.sv | 14 +
 rtl/register_file.sv | 115 +++++++++++
 tb/tb_register_file.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/tiny16_pkg.sv
// Shared tiny16 constants: data width, register index width and the fixed
// register map used by both the controller and the register file.
package tiny16_pkg;

  localparam int WORD_W    = 16;
  localparam int REG_IDX_W = 4;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 4'd0;
  localparam logic [REG_IDX_W-1:0] REG_PC   = 4'd1;
  localparam logic [REG_IDX_W-1:0] REG_SP   = 4'd2;
  localparam logic [REG_IDX_W-1:0] REG_BP   = 4'd3;
  localparam logic [REG_IDX_W-1:0] REG_RES  = 4'd15;

endpackage

// File: rtl/register_file.sv
// tiny16 sixteen-entry register file: r0 reads zero, r1/r2 are PC/SP with their
// own increment/decrement hardware, r3..r15 are plain storage.
module register_file
  import tiny16_pkg::*;
#(
  parameter logic [15:0] SP_INIT = 16'hFFFF,
  parameter logic [15:0] PC_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  input  logic [3:0]  src_sel,
  input  logic [3:0]  dst_sel,
  input  logic        in_en,
  input  logic        up_en,
  input  logic        lo_en,
  input  logic        out_en,
  input  logic        pc_inc,
  input  logic        sp_inc,
  input  logic        sp_dec,
  output logic [15:0] out,
  output logic [15:0] pc,
  output logic [15:0] sp
);

  logic [WORD_W-1:0] pc_r;
  logic [WORD_W-1:0] sp_r;
  logic [WORD_W-1:0] gp_r [REG_BP:REG_RES];
  logic [WORD_W-1:0] dst_cur_s;
  logic [WORD_W-1:0] wr_data_s;
  logic              wr_en_s;

  function automatic logic [WORD_W-1:0] read_reg(input logic [REG_IDX_W-1:0] idx);
    logic [WORD_W-1:0] val;
    case (idx)
      REG_ZERO: val = 16'h0000;
      REG_PC:   val = pc_r;
      REG_SP:   val = sp_r;
      default:  val = gp_r[idx];
    endcase
    return val;
  endfunction

  // Combinational read port; also fetches the destination for byte merges.
  always_comb begin
    dst_cur_s = read_reg(dst_sel);
    if (out_en) begin
      out = read_reg(src_sel);
    end else begin
      out = 16'h0000;
    end
  end

  // Write-enable priority: full word, then upper-byte merge, then zero-extended low byte.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_data_s = dst_cur_s;
    if (in_en) begin
      wr_en_s   = 1'b1;
      wr_data_s = in;
    end else if (up_en) begin
      wr_en_s   = 1'b1;
      wr_data_s = {in[7:0], dst_cur_s[7:0]};
    end else if (lo_en) begin
      wr_en_s   = 1'b1;
      wr_data_s = {8'h00, in[7:0]};
    end else begin
      wr_en_s   = 1'b0;
    end
    if (dst_sel == REG_ZERO) begin
      wr_en_s = 1'b0;
    end else begin
      wr_en_s = wr_en_s;
    end
  end

  // PC: an explicit write (branch taken) beats the fetch increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= PC_INIT;
    end else if (wr_en_s && dst_sel == REG_PC) begin
      pc_r <= wr_data_s;
    end else if (pc_inc) begin
      pc_r <= pc_r + 16'd1;
    end
  end

  // SP: explicit write wins; simultaneous inc and dec cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_r <= SP_INIT;
    end else if (wr_en_s && dst_sel == REG_SP) begin
      sp_r <= wr_data_s;
    end else if (sp_inc && !sp_dec) begin
      sp_r <= sp_r + 16'd1;
    end else if (sp_dec && !sp_inc) begin
      sp_r <= sp_r - 16'd1;
    end
  end

  // General-purpose storage r3..r15.
  always_ff @(posedge clk) begin
    for (int i = int'(REG_BP); i <= int'(REG_RES); i++) begin
      if (rst) begin
        gp_r[i] <= 16'h0000;
      end else if (wr_en_s && dst_sel == REG_IDX_W'(i)) begin
        gp_r[i] <= wr_data_s;
      end
    end
  end

  assign pc = pc_r;
  assign sp = sp_r;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues hand-computed expectations,
// a monitor pops and compares them mid-cycle before the next rising edge.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in;
  logic [3:0]  src_sel, dst_sel;
  logic        in_en, up_en, lo_en, out_en, pc_inc, sp_inc, sp_dec;
  logic [15:0] out, pc, sp;

  typedef struct {
    string       name;
    int          kind;   // 0 = out, 1 = pc, 2 = sp
    logic [15:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  register_file #(.SP_INIT(16'hFFFF), .PC_INIT(16'h0000)) dut (
    .clk(clk), .rst(rst), .in(in), .src_sel(src_sel), .dst_sel(dst_sel),
    .in_en(in_en), .up_en(up_en), .lo_en(lo_en), .out_en(out_en),
    .pc_inc(pc_inc), .sp_inc(sp_inc), .sp_dec(sp_dec),
    .out(out), .pc(pc), .sp(sp)
  );

  always #5 clk = ~clk;

  // Drive one cycle of strobes just after the falling edge, like the controller.
  task automatic drive(input logic [15:0] d, input logic [3:0] s, input logic [3:0] t,
                       input logic ie, input logic ue, input logic le, input logic oe,
                       input logic pi, input logic si, input logic sd, input logic r);
    @(negedge clk);
    #1;
    in = d; src_sel = s; dst_sel = t;
    in_en = ie; up_en = ue; lo_en = le; out_en = oe;
    pc_inc = pi; sp_inc = si; sp_dec = sd; rst = r;
  endtask

  task automatic idle_read(input logic [3:0] s);
    drive(16'h0000, s, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_val(input string name, input int kind, input logic [15:0] v);
    exp_t e;
    e.name = name; e.kind = kind; e.exp = v;
    exp_q.push_back(e);
  endtask

  // Monitor: compares everything queued for this cycle before the rising edge.
  initial begin
    exp_t e;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      #3;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.kind)
          1:       act = pc;
          2:       act = sp;
          default: act = out;
        endcase
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in = 16'h0000; src_sel = 4'd0; dst_sel = 4'd0;
    in_en = 1'b0; up_en = 1'b0; lo_en = 1'b0; out_en = 1'b0;
    pc_inc = 1'b0; sp_inc = 1'b0; sp_dec = 1'b0;
    drive(16'h0000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset state
    idle_read(4'd1);
    expect_val("rst_out_r1", 0, 16'h0000);
    expect_val("rst_pc", 1, 16'h0000);
    expect_val("rst_sp", 2, 16'hFFFF);
    idle_read(4'd2);
    expect_val("rst_out_r2", 0, 16'hFFFF);
    idle_read(4'd0);
    expect_val("rst_out_r0", 0, 16'h0000);

    // LLI / LUI byte building
    drive(16'h12AB, 4'd0, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(16'h0034, 4'd0, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_read(4'd4);
    expect_val("lui_lli_r4", 0, 16'h34AB);
    drive(16'h0056, 4'd4, 4'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_val("r4_pre_edge", 0, 16'h34AB);
    idle_read(4'd4);
    expect_val("lli_r4", 0, 16'h0056);

    // Enable priority
    drive(16'hA5C3, 4'd0, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(16'h0077, 4'd0, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_read(4'd6);
    expect_val("prio_r6", 0, 16'h77C3);
    drive(16'h00FF, 4'd0, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_read(4'd15);
    expect_val("r15", 0, 16'h00FF);

    // r0 write ignored, out_en low gives zero
    drive(16'hBEEF, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_read(4'd0);
    expect_val("r0_zero", 0, 16'h0000);
    drive(16'h0000, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_val("out_en_low", 0, 16'h0000);

    // PC wrap and branch priority
    drive(16'hFFFE, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(16'h0000, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_val("pc_fffe", 1, 16'hFFFE);
    drive(16'h0000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_val("pc_ffff", 1, 16'hFFFF);
    drive(16'h0040, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_val("pc_wrap", 1, 16'h0000);
    idle_read(4'd1);
    expect_val("pc_branch", 1, 16'h0040);
    expect_val("pc_branch_out", 0, 16'h0040);
    drive(16'h9999, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_read(4'd4);
    expect_val("pc_inc_par", 1, 16'h0041);
    expect_val("r4_par", 0, 16'h9999);

    // SP wrap, cancel, write priority
    drive(16'h0000, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(16'h0000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_val("sp_zero", 2, 16'h0000);
    drive(16'h0000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_val("sp_dec_wrap", 2, 16'hFFFF);
    drive(16'h0100, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_val("sp_inc_dec", 2, 16'hFFFF);
    drive(16'h0000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_val("sp_write_prio", 2, 16'h0100);
    drive(16'hFFFF, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_val("sp_inc", 2, 16'h0101);
    drive(16'h0000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_read(4'd2);
    expect_val("sp_inc_wrap", 2, 16'h0000);

    // Read-during-write, then reset discards a pending write
    drive(16'h1111, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(16'h2222, 4'd5, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_val("rdw_pre", 0, 16'h1111);
    drive(16'h3333, 4'd5, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_val("rdw_post", 0, 16'h2222);
    idle_read(4'd5);
    expect_val("rst_r5", 0, 16'h0000);
    expect_val("rst2_pc", 1, 16'h0000);
    expect_val("rst2_sp", 2, 16'hFFFF);
    idle_read(4'd6);
    expect_val("rst_r6", 0, 16'h0000);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #5;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
